// File: rtl/multi_channel_watchdog.sv
// N-channel heartbeat watchdog with programmable timeouts,
// warning threshold and trip-count lockout escalation.
module multi_channel_watchdog #(
  parameter int NUM_CH      = 4,
  parameter int CLK_FREQ    = 1,
  parameter int TIMEOUT_SEC = 5,
  parameter int WARN_PCT    = 80,
  parameter int MAX_TRIPS   = 3,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic [NUM_CH-1:0] force_reset,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [7:0]        cfg_timeout,
  input  logic [CW-1:0]     mon_ch,
  output logic [NUM_CH-1:0] triggered,
  output logic [NUM_CH-1:0] warning,
  output logic [NUM_CH-1:0] locked,
  output logic              any_triggered,
  output logic [7:0]        time_remaining
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] TRIP    = 2'd2;
  localparam logic [1:0] LOCKOUT = 2'd3;

  logic [1:0]    r_state [NUM_CH];
  logic [31:0]   r_cnt   [NUM_CH];
  logic [3:0]    r_trips [NUM_CH];
  logic [7:0]    r_tsec  [NUM_CH];
  logic [CW-1:0] r_mon_ch;

  logic [31:0] w_t     [NUM_CH];
  logic [39:0] w_prod  [NUM_CH];
  logic [31:0] w_w     [NUM_CH];
  logic [3:0]  w_trnx  [NUM_CH];
  logic [31:0] w_rem;
  logic [31:0] w_sel_t;
  logic [31:0] w_sel_cnt;
  logic        w_sel_trig;
  logic        w_sel_ok;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_t[c]    = 32'(r_tsec[c]) * 32'(CLK_FREQ);
      w_prod[c] = (40'(w_t[c]) * 40'(WARN_PCT)) / 40'd100;
      w_w[c]    = (w_prod[c] == 40'd0) ? 32'd1 : w_prod[c][31:0];
      w_trnx[c] = (r_trips[c] == 4'hF) ? 4'hF : r_trips[c] + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mon_ch <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= IDLE;
        r_cnt[c]   <= '0;
        r_trips[c] <= '0;
        r_tsec[c]  <= 8'(TIMEOUT_SEC);
      end
    end else begin
      r_mon_ch <= mon_ch;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!enable[c]) begin
          r_state[c] <= IDLE;
          r_cnt[c]   <= '0;
          r_trips[c] <= '0;
        end else if (force_reset[c]) begin
          r_state[c] <= RUN;
          r_cnt[c]   <= '0;
          r_trips[c] <= '0;
        end else if (cfg_we && cfg_ch == CW'(c)) begin
          // zero is promoted so a channel can never have T == 0
          r_tsec[c] <= (cfg_timeout == 8'd0) ? 8'd1 : cfg_timeout;
          r_cnt[c]  <= '0;
        end else if (heartbeat[c] && r_state[c] == RUN) begin
          r_cnt[c]   <= '0;
          r_trips[c] <= '0;
        end else if (heartbeat[c] && r_state[c] == TRIP) begin
          r_state[c] <= RUN;
          r_cnt[c]   <= '0;
        end else begin
          unique case (r_state[c])
            IDLE: begin
              r_state[c] <= RUN;
              r_cnt[c]   <= '0;
            end
            RUN: begin
              if (r_cnt[c] < w_t[c]) begin
                r_cnt[c] <= r_cnt[c] + 32'd1;
              end else begin
                r_cnt[c]   <= w_t[c];
                r_trips[c] <= w_trnx[c];
                r_state[c] <= (w_trnx[c] >= 4'(MAX_TRIPS)) ? LOCKOUT : TRIP;
              end
            end
            default: r_cnt[c] <= w_t[c];
          endcase
        end
      end
    end
  end

  always_comb begin
    triggered = '0;
    warning   = '0;
    locked    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      triggered[c] = (r_state[c] == TRIP) || (r_state[c] == LOCKOUT);
      locked[c]    = (r_state[c] == LOCKOUT);
      warning[c]   = triggered[c] ||
                     ((r_state[c] == RUN) && (r_cnt[c] >= w_w[c]));
    end
    any_triggered = |triggered;
  end

  // monitor select is registered so no input reaches an output directly
  always_comb begin
    w_sel_ok   = 1'b0;
    w_sel_t    = '0;
    w_sel_cnt  = '0;
    w_sel_trig = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_mon_ch == CW'(c)) begin
        w_sel_ok   = 1'b1;
        w_sel_t    = w_t[c];
        w_sel_cnt  = r_cnt[c];
        w_sel_trig = triggered[c];
      end
    end
    w_rem = '0;
    if (w_sel_ok && !w_sel_trig && (w_sel_cnt < w_sel_t)) begin
      w_rem = (w_sel_t - w_sel_cnt) / 32'(CLK_FREQ);
    end
    time_remaining = (w_rem > 32'd255) ? 8'hFF : w_rem[7:0];
  end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed testbench for multi_channel_watchdog
// using default parameters (T=5, W=4).
module tb_multi_channel_watchdog;

  logic       clk;
  logic       rstn;
  logic [3:0] enable;
  logic [3:0] heartbeat;
  logic [3:0] force_reset;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_timeout;
  logic [1:0] mon_ch;
  logic [3:0] triggered;
  logic [3:0] warning;
  logic [3:0] locked;
  logic       any_triggered;
  logic [7:0] time_remaining;

  int checks;
  int errors;

  multi_channel_watchdog dut (
    .clk            (clk),
    .rstn           (rstn),
    .enable         (enable),
    .heartbeat      (heartbeat),
    .force_reset    (force_reset),
    .cfg_we         (cfg_we),
    .cfg_ch         (cfg_ch),
    .cfg_timeout    (cfg_timeout),
    .mon_ch         (mon_ch),
    .triggered      (triggered),
    .warning        (warning),
    .locked         (locked),
    .any_triggered  (any_triggered),
    .time_remaining (time_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    enable = '0;
    heartbeat = '0;
    force_reset = '0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_timeout = '0;
    mon_ch = '0;
    #1 rstn = 1'b0;
    #2;
    checks++;
    if (triggered !== 4'b0000) begin
      errors++;
      $display("FAIL rst_trig got %b exp 0000", triggered);
    end
    checks++;
    if (warning !== 4'b0000 || locked !== 4'b0000) begin
      errors++;
      $display("FAIL rst_warn_lock got %b %b exp 0000 0000", warning, locked);
    end
    checks++;
    if (any_triggered !== 1'b0) begin
      errors++;
      $display("FAIL rst_any got %b exp 0", any_triggered);
    end
    checks++;
    if (time_remaining !== 8'd5) begin
      errors++;
      $display("FAIL rst_trem got %0d exp 5", time_remaining);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_count();
    logic [7:0] exp_tr;
    logic       exp_w;
    mon_ch = 2'd0;
    enable = 4'b0001;
    for (int i = 0; i <= 5; i++) begin
      tick();
      exp_tr = 8'(5 - i);
      exp_w = (i >= 4);
      checks++;
      if (time_remaining !== exp_tr) begin
        errors++;
        $display("FAIL cnt_trem i=%0d got %0d exp %0d", i, time_remaining, exp_tr);
      end
      checks++;
      if (warning[0] !== exp_w || triggered[0] !== 1'b0) begin
        errors++;
        $display("FAIL cnt_warn i=%0d got w=%b t=%b exp w=%b t=0",
                 i, warning[0], triggered[0], exp_w);
      end
    end
    tick();
    checks++;
    if (triggered !== 4'b0001 || any_triggered !== 1'b1) begin
      errors++;
      $display("FAIL cnt_trip got %b any=%b exp 0001 any=1", triggered, any_triggered);
    end
    checks++;
    if (warning[0] !== 1'b1 || time_remaining !== 8'd0) begin
      errors++;
      $display("FAIL cnt_trip_wt got w=%b tr=%0d exp w=1 tr=0", warning[0], time_remaining);
    end
  endtask

  task automatic test_heartbeat();
    enable = 4'b0000;
    tick();
    enable = 4'b0001;
    tick();
    repeat (4) tick();
    checks++;
    if (warning[0] !== 1'b1) begin
      errors++;
      $display("FAIL hb_prewarn got %b exp 1", warning[0]);
    end
    heartbeat = 4'b0001;
    tick();
    heartbeat = 4'b0000;
    checks++;
    if (warning[0] !== 1'b0 || time_remaining !== 8'd5) begin
      errors++;
      $display("FAIL hb_clear got w=%b tr=%0d exp w=0 tr=5", warning[0], time_remaining);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (triggered[0] !== 1'b0) begin
        errors++;
        $display("FAIL hb_notrig i=%0d got %b exp 0", i, triggered[0]);
      end
    end
    tick();
    checks++;
    if (triggered[0] !== 1'b1 || locked[0] !== 1'b0) begin
      errors++;
      $display("FAIL hb_trip1 got t=%b l=%b exp t=1 l=0", triggered[0], locked[0]);
    end
    heartbeat = 4'b0001;
    tick();
    heartbeat = 4'b0000;
    checks++;
    if (triggered[0] !== 1'b0 || time_remaining !== 8'd5) begin
      errors++;
      $display("FAIL hb_recover got t=%b tr=%0d exp t=0 tr=5", triggered[0], time_remaining);
    end
    repeat (6) tick();
    checks++;
    if (triggered[0] !== 1'b1 || locked[0] !== 1'b0) begin
      errors++;
      $display("FAIL hb_trip2 got t=%b l=%b exp t=1 l=0", triggered[0], locked[0]);
    end
    heartbeat = 4'b0001;
    tick();
    heartbeat = 4'b0000;
    repeat (6) tick();
    checks++;
    if (locked[0] !== 1'b1) begin
      errors++;
      $display("FAIL hb_trip3_lock got %b exp 1", locked[0]);
    end
    enable = 4'b0000;
    tick();
  endtask

  task automatic test_lockout();
    logic exp_l;
    mon_ch = 2'd1;
    enable = 4'b0010;
    tick();
    for (int k = 1; k <= 3; k++) begin
      repeat (6) tick();
      exp_l = (k == 3);
      checks++;
      if (triggered[1] !== 1'b1 || locked[1] !== exp_l) begin
        errors++;
        $display("FAIL lk_trip k=%0d got t=%b l=%b exp t=1 l=%b",
                 k, triggered[1], locked[1], exp_l);
      end
      if (k < 3) begin
        heartbeat = 4'b0010;
        tick();
        heartbeat = 4'b0000;
        checks++;
        if (triggered[1] !== 1'b0) begin
          errors++;
          $display("FAIL lk_hb k=%0d got %b exp 0", k, triggered[1]);
        end
      end
    end
    heartbeat = 4'b0010;
    tick();
    tick();
    heartbeat = 4'b0000;
    checks++;
    if (triggered[1] !== 1'b1 || locked[1] !== 1'b1 || time_remaining !== 8'd0) begin
      errors++;
      $display("FAIL lk_ignore_hb got t=%b l=%b tr=%0d exp t=1 l=1 tr=0",
               triggered[1], locked[1], time_remaining);
    end
    force_reset = 4'b0010;
    tick();
    force_reset = 4'b0000;
    checks++;
    if (triggered[1] !== 1'b0 || locked[1] !== 1'b0 || time_remaining !== 8'd5) begin
      errors++;
      $display("FAIL lk_force got t=%b l=%b tr=%0d exp t=0 l=0 tr=5",
               triggered[1], locked[1], time_remaining);
    end
    repeat (6) tick();
    checks++;
    if (triggered[1] !== 1'b1 || locked[1] !== 1'b0) begin
      errors++;
      $display("FAIL lk_trips_cleared got t=%b l=%b exp t=1 l=0", triggered[1], locked[1]);
    end
    enable = 4'b0000;
    tick();
  endtask

  task automatic test_cfg();
    mon_ch = 2'd2;
    enable = 4'b0100;
    tick();
    tick();
    tick();
    checks++;
    if (time_remaining !== 8'd3) begin
      errors++;
      $display("FAIL cfg_pre got %0d exp 3", time_remaining);
    end
    cfg_we = 1'b1;
    cfg_ch = 2'd2;
    cfg_timeout = 8'd10;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (time_remaining !== 8'd10 || warning[2] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_load got tr=%0d w=%b exp tr=10 w=0", time_remaining, warning[2]);
    end
    repeat (7) tick();
    checks++;
    if (time_remaining !== 8'd3 || warning[2] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_c7 got tr=%0d w=%b exp tr=3 w=0", time_remaining, warning[2]);
    end
    tick();
    checks++;
    if (time_remaining !== 8'd2 || warning[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_c8 got tr=%0d w=%b exp tr=2 w=1", time_remaining, warning[2]);
    end
    repeat (2) tick();
    checks++;
    if (time_remaining !== 8'd0 || triggered[2] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_c10 got tr=%0d t=%b exp tr=0 t=0", time_remaining, triggered[2]);
    end
    tick();
    checks++;
    if (triggered[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_trip got %b exp 1", triggered[2]);
    end
    cfg_we = 1'b1;
    cfg_timeout = 8'd0;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (triggered[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_wr_in_trip got %b exp 1", triggered[2]);
    end
    heartbeat = 4'b0100;
    tick();
    heartbeat = 4'b0000;
    checks++;
    if (time_remaining !== 8'd1 || triggered[2] !== 1'b0 || warning[2] !== 1'b0) begin
      errors++;
      $display("FAIL cfg_t1_c0 got tr=%0d t=%b w=%b exp tr=1 t=0 w=0",
               time_remaining, triggered[2], warning[2]);
    end
    tick();
    checks++;
    if (time_remaining !== 8'd0 || triggered[2] !== 1'b0 || warning[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_t1_c1 got tr=%0d t=%b w=%b exp tr=0 t=0 w=1",
               time_remaining, triggered[2], warning[2]);
    end
    tick();
    checks++;
    if (triggered[2] !== 1'b1) begin
      errors++;
      $display("FAIL cfg_t1_trip got %b exp 1", triggered[2]);
    end
    enable = 4'b0000;
    tick();
  endtask

  task automatic test_simultaneous();
    mon_ch = 2'd3;
    enable = 4'b1000;
    tick();
    for (int k = 1; k <= 3; k++) begin
      repeat (6) tick();
      if (k < 3) begin
        heartbeat = 4'b1000;
        tick();
        heartbeat = 4'b0000;
      end
    end
    checks++;
    if (locked[3] !== 1'b1 || triggered[3] !== 1'b1) begin
      errors++;
      $display("FAIL sim_lock got l=%b t=%b exp l=1 t=1", locked[3], triggered[3]);
    end
    enable = 4'b1001;
    tick();
    tick();
    enable = 4'b0001;
    heartbeat = 4'b1000;
    force_reset = 4'b1000;
    cfg_we = 1'b1;
    cfg_ch = 2'd3;
    cfg_timeout = 8'd7;
    mon_ch = 2'd0;
    tick();
    heartbeat = 4'b0000;
    force_reset = 4'b0000;
    cfg_we = 1'b0;
    checks++;
    if (triggered !== 4'b0000 || warning !== 4'b0000 || locked !== 4'b0000) begin
      errors++;
      $display("FAIL sim_idle got t=%b w=%b l=%b exp 0000 0000 0000",
               triggered, warning, locked);
    end
    checks++;
    if (time_remaining !== 8'd3 || any_triggered !== 1'b0) begin
      errors++;
      $display("FAIL sim_ch0 got tr=%0d any=%b exp tr=3 any=0", time_remaining, any_triggered);
    end
    tick();
    checks++;
    if (time_remaining !== 8'd2) begin
      errors++;
      $display("FAIL sim_ch0_next got %0d exp 2", time_remaining);
    end
    mon_ch = 2'd3;
    tick();
    checks++;
    if (time_remaining !== 8'd5) begin
      errors++;
      $display("FAIL sim_ch3_tsec got %0d exp 5", time_remaining);
    end
    enable = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    mon_ch = 2'd0;
    enable = 4'b0001;
    cfg_we = 1'b1;
    cfg_ch = 2'd0;
    cfg_timeout = 8'd2;
    tick();
    cfg_we = 1'b0;
    checks++;
    if (time_remaining !== 8'd2) begin
      errors++;
      $display("FAIL ar_cfg got %0d exp 2", time_remaining);
    end
    repeat (4) tick();
    checks++;
    if (triggered !== 4'b0001 || time_remaining !== 8'd0) begin
      errors++;
      $display("FAIL ar_trip got t=%b tr=%0d exp t=0001 tr=0", triggered, time_remaining);
    end
    #3 rstn = 1'b0;
    #1;
    checks++;
    if (triggered !== 4'b0000 || warning !== 4'b0000 || any_triggered !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got t=%b w=%b any=%b exp 0000 0000 0",
               triggered, warning, any_triggered);
    end
    checks++;
    if (time_remaining !== 8'd5 || locked !== 4'b0000) begin
      errors++;
      $display("FAIL ar_tsec got tr=%0d l=%b exp tr=5 l=0000", time_remaining, locked);
    end
    enable = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count();
    test_heartbeat();
    test_lockout();
    test_cfg();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
